// File: rtl/dsp19x2_post_accumulator_if.sv
// rtl/dsp19x2_post_accumulator_if.sv - stream bundle between DSP19X2, post accumulator and downstream
//
// Purpose: groups the input beat (Z1/Z2 plus controls), its handshake, and the
// narrowed output beat with its handshake.
//   slave  : post accumulator side (consumes input beat, produces output beat)
//   master : upstream/downstream side (produces input beat, consumes output beat)
// Signals:
//   in_valid_i / in_ready_o     input beat handshake
//   z1_i, z2_i                  19-bit lane products
//   unsigned_i                  1: unsigned arithmetic, 0: signed
//   load_acc_i, subtract_i      accumulate mode (load wins over subtract)
//   shift_right_i, round_i      output scaling controls
//   out_valid_o / out_ready_i   output beat handshake
//   acc1_out_o, acc2_out_o      19-bit narrowed lane results
//   overflow_o                  per-lane narrowing clamp flag, bit0 = lane 1

interface dsp19x2_post_accumulator_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [18:0] z1_i;
  logic [18:0] z2_i;
  logic        unsigned_i;
  logic        load_acc_i;
  logic        subtract_i;
  logic [4:0]  shift_right_i;
  logic        round_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [18:0] acc1_out_o;
  logic [18:0] acc2_out_o;
  logic [1:0]  overflow_o;

  modport slave (
    input  in_valid_i, z1_i, z2_i, unsigned_i, load_acc_i, subtract_i,
           shift_right_i, round_i, out_ready_i,
    output in_ready_o, out_valid_o, acc1_out_o, acc2_out_o, overflow_o
  );

  modport master (
    output in_valid_i, z1_i, z2_i, unsigned_i, load_acc_i, subtract_i,
           shift_right_i, round_i, out_ready_i,
    input  in_ready_o, out_valid_o, acc1_out_o, acc2_out_o, overflow_o
  );
endinterface

// File: rtl/dsp19x2_post_accumulator.sv
// rtl/dsp19x2_post_accumulator.sv - dual-lane accumulate, shift, round and narrow stage after DSP19X2
//
// Purpose: each lane accumulates its 19-bit product into an ACC_WIDTH-bit
// accumulator (stage 1), then rounds, shifts and narrows the accumulator to
// 19 bits (stage 2). Both lanes share controls and handshake.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset
//   bus     dsp19x2_post_accumulator_if.slave (input beat, output beat)
// Parameters:
//   ACC_WIDTH  accumulator width, 20..48
// Configuration macro:
//   DSP19X2_POST_SATURATE_EN  defined: clamp narrowed result and report OVERFLOW;
//                             undefined: keep low 19 bits, OVERFLOW = 0

module dsp19x2_post_accumulator #(
  parameter int ACC_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  dsp19x2_post_accumulator_if.slave     bus
);

  localparam int W = ACC_WIDTH;
  localparam logic [W:0] ONE_W1 = {{W{1'b0}}, 1'b1};

  logic           adv;
  logic           accept;

  logic [W-1:0]   acc1_q, acc1_d;
  logic [W-1:0]   acc2_q, acc2_d;
  logic           s1_valid_q;
  logic           s1_uns_q;
  logic           s1_round_q;
  logic [4:0]     s1_shift_q;

  logic           out_valid_q;
  logic [18:0]    acc1_out_q, acc1_out_d;
  logic [18:0]    acc2_out_q, acc2_out_d;

  logic [W:0]     shifted1, shifted2;

  // Sign- or zero-extend a 19-bit product to accumulator width.
  function automatic logic [W-1:0] ext19(input logic [18:0] z, input logic uns);
    if (uns) ext19 = {{(W-19){1'b0}}, z};
    else     ext19 = {{(W-19){z[18]}}, z};
  endfunction

  // Accumulator update; wraps modulo 2^W, load has priority over subtract.
  function automatic logic [W-1:0] acc_next(input logic [W-1:0] acc,
                                            input logic [18:0]  z,
                                            input logic         uns,
                                            input logic         ld,
                                            input logic         sub);
    logic [W-1:0] e;
    e = ext19(z, uns);
    if (ld)       acc_next = e;
    else if (sub) acc_next = acc - e;
    else          acc_next = acc + e;
  endfunction

  // Round-half-up then shift, computed one bit wider than the accumulator so
  // the rounding increment can never wrap the value.
  function automatic logic [W:0] shift_round(input logic [W-1:0] acc,
                                             input logic         uns,
                                             input logic [4:0]   sh,
                                             input logic         rnd);
    logic [W:0]        wide;
    logic [W:0]        rc;
    logic [W:0]        sum;
    logic [W:0]        sh_u;
    logic signed [W:0] sh_s;
    wide = uns ? {1'b0, acc} : {acc[W-1], acc};
    rc   = '0;
    if (rnd && (sh != 5'd0)) rc = ONE_W1 << (sh - 5'd1);
    sum  = wide + rc;
    sh_u = sum >> sh;
    sh_s = $signed(sum) >>> sh;
    if (uns) shift_round = sh_u;
    else     shift_round = sh_s;
  endfunction

`ifdef DSP19X2_POST_SATURATE_EN
  logic [1:0]  ovf_q, ovf_d;

  // Returns {overflow, 19-bit clamped value}.
  function automatic logic [19:0] saturate(input logic [W:0] v, input logic uns);
    if (uns) begin
      // Unsigned values are never negative here; only the upper bound matters.
      if (|v[W:19]) saturate = {1'b1, 19'h7FFFF};
      else          saturate = {1'b0, v[18:0]};
    end else begin
      // Fits in 19 signed bits when every bit from the sign down to bit 18 agrees.
      if ((&v[W:18]) || !(|v[W:18])) saturate = {1'b0, v[18:0]};
      else if (v[W])                 saturate = {1'b1, 19'h40000};
      else                           saturate = {1'b1, 19'h3FFFF};
    end
  endfunction
`endif

  assign adv    = !out_valid_q || bus.out_ready_i;
  assign accept = bus.in_valid_i && adv && !rst_i;

  assign bus.in_ready_o  = adv && !rst_i;
  assign bus.out_valid_o = out_valid_q;
  assign bus.acc1_out_o  = acc1_out_q;
  assign bus.acc2_out_o  = acc2_out_q;

  always_comb begin
    acc1_d = acc1_q;
    acc2_d = acc2_q;
    if (accept) begin
      acc1_d = acc_next(acc1_q, bus.z1_i, bus.unsigned_i, bus.load_acc_i, bus.subtract_i);
      acc2_d = acc_next(acc2_q, bus.z2_i, bus.unsigned_i, bus.load_acc_i, bus.subtract_i);
    end
  end

  // Stage 2 reads the accumulator directly: whenever s1_valid_q is set the
  // accumulator holds exactly the result of the beat that set it.
  always_comb begin
    shifted1 = shift_round(acc1_q, s1_uns_q, s1_shift_q, s1_round_q);
    shifted2 = shift_round(acc2_q, s1_uns_q, s1_shift_q, s1_round_q);
  end

`ifdef DSP19X2_POST_SATURATE_EN
  always_comb begin
    logic [19:0] r1;
    logic [19:0] r2;
    r1 = saturate(shifted1, s1_uns_q);
    r2 = saturate(shifted2, s1_uns_q);
    acc1_out_d = r1[18:0];
    acc2_out_d = r2[18:0];
    ovf_d      = {r2[19], r1[19]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 2'b00;
    end else if (adv && s1_valid_q) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.overflow_o = ovf_q;
`else
  always_comb begin
    acc1_out_d = shifted1[18:0];
    acc2_out_d = shifted2[18:0];
  end

  assign bus.overflow_o = 2'b00;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc1_q      <= '0;
      acc2_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_uns_q    <= 1'b0;
      s1_round_q  <= 1'b0;
      s1_shift_q  <= 5'd0;
      out_valid_q <= 1'b0;
      acc1_out_q  <= 19'd0;
      acc2_out_q  <= 19'd0;
    end else if (adv) begin
      acc1_q      <= acc1_d;
      acc2_q      <= acc2_d;
      s1_valid_q  <= accept;
      if (accept) begin
        s1_uns_q   <= bus.unsigned_i;
        s1_round_q <= bus.round_i;
        s1_shift_q <= bus.shift_right_i;
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        acc1_out_q <= acc1_out_d;
        acc2_out_q <= acc2_out_d;
      end
    end
  end

endmodule

// File: tb/tb_dsp19x2_post_accumulator.sv
// tb/tb_dsp19x2_post_accumulator.sv - directed self-checking bench for dsp19x2_post_accumulator

module tb_dsp19x2_post_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  dsp19x2_post_accumulator_if bus();

  dsp19x2_post_accumulator #(.ACC_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic sub, input logic uns,
                       input logic [4:0] sh, input logic rnd,
                       input logic [18:0] a, input logic [18:0] b);
    bus.in_valid_i    = v;
    bus.load_acc_i    = ld;
    bus.subtract_i    = sub;
    bus.unsigned_i    = uns;
    bus.shift_right_i = sh;
    bus.round_i       = rnd;
    bus.z1_i          = a;
    bus.z2_i          = b;
  endtask

  task automatic idle();
    bus.in_valid_i = 1'b0;
  endtask

  // One isolated beat; returns when its result is on the outputs.
  task automatic send(input logic ld, input logic sub, input logic uns,
                      input logic [4:0] sh, input logic rnd,
                      input logic [18:0] a, input logic [18:0] b);
    drive(1'b1, ld, sub, uns, sh, rnd, a, b);
    step();
    idle();
    step();
  endtask

  logic [18:0] z5   [6] = '{19'd10, 19'd1, 19'd2, 19'd3, 19'd4, 19'd5};
  logic [18:0] exp5 [6] = '{19'd10, 19'd11, 19'd13, 19'd16, 19'd20, 19'd25};

  initial begin
    int  nb;
    int  k;
    int  stalls;
    logic acc;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 19'd0, 19'd0);
    bus.out_ready_i = 1'b1;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_in_ready",  {31'd0, bus.in_ready_o}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("rst_acc1",      {13'd0, bus.acc1_out_o}, 32'd0);
    chk("rst_acc2",      {13'd0, bus.acc2_out_o}, 32'd0);
    chk("rst_ovf",       {30'd0, bus.overflow_o}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);

    // 1: signed load, two-cycle latency
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 19'd100, 19'h7FFFB);
    step();
    idle();
    chk("t1_not_yet_valid", {31'd0, bus.out_valid_o}, 32'd0);
    step();
    chk("t1_valid", {31'd0, bus.out_valid_o}, 32'd1);
    chk("t1_acc1",  {13'd0, bus.acc1_out_o}, 32'd100);
    chk("t1_acc2",  {13'd0, bus.acc2_out_o}, 32'h7FFFB);

    // 2: back-to-back accumulate
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 19'd1000, 19'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 19'd1000, 19'd0);
    step();
    chk("t2_b0", {13'd0, bus.acc1_out_o}, 32'd1000);
    step();
    chk("t2_b1", {13'd0, bus.acc1_out_o}, 32'd2000);
    chk("t2_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    step();
    chk("t2_b2", {13'd0, bus.acc1_out_o}, 32'd3000);
    idle();
    step();
    chk("t2_b3", {13'd0, bus.acc1_out_o}, 32'd4000);
    chk("t2_b3_valid", {31'd0, bus.out_valid_o}, 32'd1);
    step();
    chk("t2_drained", {31'd0, bus.out_valid_o}, 32'd0);

    // 3: rounding, shift, subtract
    send(1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 19'd7, 19'h7FFFF);
    chk("t3_round_on",   {13'd0, bus.acc1_out_o}, 32'd4);
    chk("t3_l2_round",   {13'd0, bus.acc2_out_o}, 32'd0);
    send(1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 19'd0, 19'd0);
    chk("t3_round_off",  {13'd0, bus.acc1_out_o}, 32'd3);
    chk("t3_l2_asr",     {13'd0, bus.acc2_out_o}, 32'h7FFFF);
    send(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 19'd10, 19'd10);
    chk("t3_sub",        {13'd0, bus.acc1_out_o}, 32'h7FFFD);
    chk("t3_l2_sub",     {13'd0, bus.acc2_out_o}, 32'h7FFF5);
    send(1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 19'd7, 19'd0);
    chk("t3_load_wins_round_sh0", {13'd0, bus.acc1_out_o}, 32'd7);
    send(1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 19'h7FFFF, 19'h7FFFF);
    chk("t3_uns_lsr",    {13'd0, bus.acc1_out_o}, 32'h07FFF);
    chk("t3_uns_lsr_l2", {13'd0, bus.acc2_out_o}, 32'h07FFF);
    send(1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 19'h7FFFF, 19'd0);
    chk("t3_uns_round",  {13'd0, bus.acc1_out_o}, 32'h40000);
    send(1'b1, 1'b0, 1'b0, 5'd4, 1'b0, 19'h7FFFF, 19'd0);
    chk("t3_sgn_asr",    {13'd0, bus.acc1_out_o}, 32'h7FFFF);

    // 4: narrowing at the 19-bit signed boundary
    send(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 19'd0, 19'd0);
    send(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 19'h3FFFF, 19'd0);
    chk("t4_max_fit",     {13'd0, bus.acc1_out_o}, 32'h3FFFF);
    chk("t4_max_fit_ovf", {30'd0, bus.overflow_o}, 32'd0);
    send(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 19'h3FFFF, 19'd0);
`ifdef DSP19X2_POST_SATURATE_EN
    chk("t4_pos_clamp",     {13'd0, bus.acc1_out_o}, 32'h3FFFF);
    chk("t4_pos_clamp_ovf", {30'd0, bus.overflow_o}, 32'd1);
`else
    chk("t4_pos_wrap",      {13'd0, bus.acc1_out_o}, 32'h7FFFE);
    chk("t4_pos_wrap_ovf",  {30'd0, bus.overflow_o}, 32'd0);
`endif
    send(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 19'h40000, 19'd0);
    send(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 19'd1, 19'd0);
`ifdef DSP19X2_POST_SATURATE_EN
    chk("t4_neg_clamp",     {13'd0, bus.acc1_out_o}, 32'h40000);
    chk("t4_neg_clamp_ovf", {30'd0, bus.overflow_o}, 32'd1);
`else
    chk("t4_neg_wrap",      {13'd0, bus.acc1_out_o}, 32'h3FFFF);
    chk("t4_neg_wrap_ovf",  {30'd0, bus.overflow_o}, 32'd0);
`endif
    step();
    chk("t4_drained", {31'd0, bus.out_valid_o}, 32'd0);

    // 5: continuous stream with a three-cycle downstream stall
    nb     = 0;
    k      = 0;
    stalls = 0;
    for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
      bus.out_ready_i = !(cyc >= 3 && cyc <= 5);
      if (nb < 6) drive(1'b1, (nb == 0), 1'b0, 1'b0, 5'd0, 1'b0, z5[nb], 19'd0);
      else        idle();
      #1;
      acc = bus.in_valid_i && bus.in_ready_o;
      if (bus.out_valid_o) begin
        if (bus.out_ready_i) begin
          chk("t5_result", {13'd0, bus.acc1_out_o}, {13'd0, exp5[k]});
          k++;
        end else begin
          stalls++;
          chk("t5_stall_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
          chk("t5_stall_hold", {13'd0, bus.acc1_out_o}, {13'd0, exp5[k]});
        end
      end
      @(posedge clk);
      #1;
      if (acc) nb++;
    end
    bus.out_ready_i = 1'b1;
    idle();
    chk("t5_outputs_seen", k, 32'd6);
    chk("t5_inputs_taken", nb, 32'd6);
    chk("t5_stall_cycles", stalls, 32'd3);

    // 6: reset with two beats in flight
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 19'd50, 19'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 19'd1, 19'd0);
    step();
    idle();
    rst = 1'b1;
    #1;
    chk("t6_in_ready_in_rst", {31'd0, bus.in_ready_o}, 32'd0);
    step();
    chk("t6_flushed", {31'd0, bus.out_valid_o}, 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 19'd5, 19'd0);
    step();
    idle();
    chk("t6_stage1_flushed", {31'd0, bus.out_valid_o}, 32'd0);
    step();
    chk("t6_valid", {31'd0, bus.out_valid_o}, 32'd1);
    chk("t6_acc_cleared", {13'd0, bus.acc1_out_o}, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
